countdown_display: RTL



---
 rtl/countdown_display_if.sv | 27 ++
 rtl/countdown_display.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/countdown_display_if.sv
// Controller-facing bundle for the countdown/display block.
//   start/stop/pause : one-cycle command pulses from the controller
//   min/sec          : configured minutes/seconds (binary, clamped inside)
//   d6               : status digit {enable, hex[3:0], dp}
//   an/dec_cat       : active-low anodes and cathodes {dp,g,f,e,d,c,b,a}
//   done             : one-cycle pulse when the countdown expires
interface countdown_display_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic [6:0] min;
  logic [6:0] sec;
  logic [5:0] d6;
  logic [7:0] an;
  logic [7:0] dec_cat;
  logic       done;

  modport master (
    output start, stop, pause, min, sec, d6,
    input  an, dec_cat, done
  );

  modport slave (
    input  start, stop, pause, min, sec, d6,
    output an, dec_cat, done
  );
endinterface

// File: rtl/countdown_display.sv
// MM:SS countdown engine at one tick per TICK_CYCLES clocks, plus an
// 8-digit multiplexed 7-segment scanner (SCAN_CYCLES clocks per digit).
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : countdown_display_if.slave (commands, config, display, done)
module countdown_display #(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned SCAN_CYCLES = 100_000
) (
  input logic            clock,
  input logic            reset,
  countdown_display_if.slave bus
);

  localparam int unsigned TICK_W = $clog2(TICK_CYCLES + 1);
  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t              state;
  logic [6:0]          cur_min;
  logic [6:0]          cur_sec;
  logic [TICK_W-1:0]   tick_cnt;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [2:0]          ptr;

  logic [6:0] min_clamp;
  logic [6:0] sec_clamp;
  logic [6:0] show_min;
  logic [6:0] show_sec;
  logic       tick_last;
  logic [3:0] digit;
  logic       digit_on;
  logic       dp_on;
  logic [7:0] an_next;
  logic [7:0] cat_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick_last = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

  always_comb begin
    min_clamp = (bus.min > 7'd99) ? 7'd99 : bus.min;
    sec_clamp = (bus.sec > 7'd59) ? 7'd59 : bus.sec;
    // IDLE previews the live configuration; otherwise show the running count.
    show_min  = (state == IDLE) ? min_clamp : cur_min;
    show_sec  = (state == IDLE) ? sec_clamp : cur_sec;

    digit    = '0;
    digit_on = 1'b0;
    dp_on    = 1'b0;
    case (ptr)
      3'd0: begin digit = 4'(show_sec % 7'd10); digit_on = 1'b1; end
      3'd1: begin digit = 4'(show_sec / 7'd10); digit_on = 1'b1; end
      3'd2: begin digit = 4'(show_min % 7'd10); digit_on = 1'b1; dp_on = 1'b1; end
      3'd3: begin digit = 4'(show_min / 7'd10); digit_on = 1'b1; end
      3'd5: begin digit = bus.d6[4:1]; digit_on = bus.d6[5]; dp_on = bus.d6[0]; end
      default: ;
    endcase

    an_next  = digit_on ? ~(8'd1 << ptr) : '1;
    cat_next = digit_on ? {~dp_on, hex7(digit)} : '1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt    <= '0;
      ptr         <= '0;
      bus.an      <= '1;
      bus.dec_cat <= '1;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
        scan_cnt <= '0;
        ptr      <= ptr + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      bus.an      <= an_next;
      bus.dec_cat <= cat_next;
    end
  end

  // Command priority stop > pause > start; a stop/pause in the final-tick
  // cycle suppresses the decrement, so no done is raised.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cur_min  <= '0;
      cur_sec  <= '0;
      tick_cnt <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cur_min  <= min_clamp;
            cur_sec  <= sec_clamp;
            tick_cnt <= '0;
            if (min_clamp == 7'd0 && sec_clamp == 7'd0) bus.done <= 1'b1;
            else state <= COUNT;
          end
        end
        COUNT: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (bus.pause) begin
            state <= HOLD;
          end else if (tick_last) begin
            tick_cnt <= '0;
            if (cur_sec != 7'd0) begin
              cur_sec <= cur_sec - 7'd1;
            end else begin
              cur_min <= cur_min - 7'd1;
              cur_sec <= 7'd59;
            end
            if (cur_min == 7'd0 && cur_sec == 7'd1) begin
              state    <= IDLE;
              bus.done <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        HOLD: begin
          if (bus.stop) state <= IDLE;
          else if (bus.pause || bus.start) state <= COUNT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
